// File: rtl/servant_uart_tx.sv
// rtl/servant_uart_tx.sv - Wishbone-mapped 8N1 UART transmitter with 8-entry write FIFO
module servant_uart_tx #(
  parameter int FIFO_AW     = 3,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 278
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rstn,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
  logic [7:0]         mem_q [DEPTH];
  logic               fifo_empty, fifo_full, push, pop;
  logic               overflow_q, overflow_d;
  logic [DIV_WIDTH-1:0] div_q, div_d, cnt_q, cnt_d, reload;
  logic [1:0]         state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d, ack_q, ack_d;
  logic [31:0]        rdt_q, rdt_d, rd_val;
  logic               accept, wr_txdata, wr_status, wr_div, bit_end;
  logic               unused_dat;

  assign level      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (level == (FIFO_AW+1)'(DEPTH));
  assign accept     = i_wb_cyc && !ack_q;
  assign wr_txdata  = accept && i_wb_we && (i_wb_adr == 2'd0);
  assign wr_status  = accept && i_wb_we && (i_wb_adr == 2'd1);
  assign wr_div     = accept && i_wb_we && (i_wb_adr == 2'd2);
  assign reload     = div_q - DIV_WIDTH'(1);
  assign bit_end    = (cnt_q == '0);
  assign unused_dat = ^i_wb_dat[31:DIV_WIDTH];

  // Bit timing: counter reloads DIV-1 at each boundary, so a DIV write lands on the next bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q[FIFO_AW-1:0]];
          cnt_d   = reload;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = reload;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = reload;
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) state_d = S_STOP;
          else idx_d = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      default: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q[FIFO_AW-1:0]];
            cnt_d   = reload;
            state_d = S_START;
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
    endcase
  end

  // Line level is registered from the next state so o_tx never glitches.
  always_comb begin
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    push       = wr_txdata && (!fifo_full || pop);
    wr_ptr_d   = wr_ptr_q + (FIFO_AW+1)'(push);
    rd_ptr_d   = rd_ptr_q + (FIFO_AW+1)'(pop);
    overflow_d = overflow_q;
    if (wr_status) overflow_d = 1'b0;
    else if (wr_txdata && fifo_full && !pop) overflow_d = 1'b1;
    div_d = div_q;
    if (wr_div) begin
      div_d = (i_wb_dat[DIV_WIDTH-1:0] == '0) ? DIV_WIDTH'(1) : i_wb_dat[DIV_WIDTH-1:0];
    end
  end

  always_comb begin
    rd_val = '0;
    case (i_wb_adr)
      2'd1: begin
        rd_val[0]              = fifo_full;
        rd_val[1]              = fifo_empty;
        rd_val[2]              = (state_q != S_IDLE);
        rd_val[3]              = overflow_q;
        rd_val[FIFO_AW+8:8]    = level;
      end
      2'd2:    rd_val[DIV_WIDTH-1:0] = div_q;
      default: rd_val = '0;
    endcase
    rdt_d = accept ? rd_val : '0;
    ack_d = accept;
  end

  always_ff @(posedge i_wb_clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= i_wb_dat[7:0];
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rstn) begin
    if (!i_wb_rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      div_q      <= DIV_WIDTH'(DEFAULT_DIV);
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      ack_q      <= 1'b0;
      rdt_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ack_q      <= ack_d;
      rdt_q      <= rdt_d;
    end
  end

  assign o_tx     = tx_q;
  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_irq    = fifo_empty && (state_q == S_IDLE);

endmodule
